// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the two-port memory arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_ack;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_ack;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_out;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata,
        output mem_we, mem_addr, mem_data,
        input  mem_out
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata,
        input  mem_we, mem_addr, mem_data,
        output mem_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one combinational-read memory between two ports; ack 2 cycles after req when idle.
// Requesters hold req until ack; the loser simply waits, alternating grants give 1 transaction per 2 cycles.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  last_grant;
    logic                  cur_port;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  load;
    logic                  load_port;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_port = 1'b0;
        case (state)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    load      = 1'b1;
                    state_nxt = ACCESS;
                    // On a tie the port that did not win last time goes first.
                    load_port = (bus.m0_req && bus.m1_req) ? ~last_grant : bus.m1_req;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
            end
            RESP: begin
                // Only the other port may chain directly; the winner's req is ignored here.
                if (cur_port ? bus.m0_req : bus.m1_req) begin
                    load      = 1'b1;
                    load_port = ~cur_port;
                    state_nxt = ACCESS;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            cur_port   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            if (load) begin
                cur_port   <= load_port;
                last_grant <= load_port;
                lat_we     <= load_port ? bus.m1_we    : bus.m0_we;
                lat_addr   <= load_port ? bus.m1_addr  : bus.m0_addr;
                lat_wdata  <= load_port ? bus.m1_wdata : bus.m0_wdata;
            end
            if (state == ACCESS && !lat_we) begin
                if (cur_port) begin
                    rdata1 <= bus.mem_out;
                end else begin
                    rdata0 <= bus.mem_out;
                end
            end
        end
    end

    assign bus.mem_we   = (state == ACCESS) && lat_we;
    assign bus.mem_addr = lat_addr;
    assign bus.mem_data = lat_wdata;
    assign bus.m0_ack   = (state == RESP) && !cur_port;
    assign bus.m1_ack   = (state == RESP) && cur_port;
    assign bus.m0_rdata = rdata0;
    assign bus.m1_rdata = rdata1;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a behavioural memory and transaction-level reference.
module tb_mem_arbiter;
    localparam int AW = 6;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [DW-1:0] mem [64];
    assign bus.mem_out = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] ref_mem [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (p == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end
    endtask

    function automatic logic get_ack(input int p);
        return (p == 0) ? bus.m0_ack : bus.m1_ack;
    endfunction

    function automatic logic [DW-1:0] get_rdata(input int p);
        return (p == 0) ? bus.m0_rdata : bus.m1_rdata;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_all();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // One transaction from an idle arbiter: ack exactly two cycles after req, one-cycle write strobe.
    task automatic do_single(input int p, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd);
        drive(p, 1'b1, we, addr, wdata);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("p%0d_ack_k%0d", p, k), 32'(get_ack(p)), 32'(k == 2));
            check($sformatf("p%0d_other_ack_k%0d", p, k), 32'(get_ack(1 - p)), 32'(0));
            check($sformatf("p%0d_mem_we_k%0d", p, k), 32'(bus.mem_we), 32'((k == 1) && we));
            if (k == 1) begin
                check("access_addr", 32'(bus.mem_addr), 32'(addr));
                if (we) check("access_data", 32'(bus.mem_data), 32'(wdata));
            end
            if (k == 2 && !we) check($sformatf("p%0d_rdata", p), 32'(get_rdata(p)), 32'(exp_rd));
            next_cycle();
        end
    endtask

    logic          pend  [2];
    logic          pwe   [2];
    logic [AW-1:0] paddr [2];
    logic [DW-1:0] pdat  [2];
    int            t0    [2];

    initial begin
        int lat;
        int nwr;
        int we_pulses;
        logic [DW-1:0] v;

        // Reset values
        rst = 1'b1;
        idle_all();
        next_cycle();
        @(negedge clk);
        check("rst_m0_ack", 32'(bus.m0_ack), 32'(0));
        check("rst_m1_ack", 32'(bus.m1_ack), 32'(0));
        check("rst_m0_rdata", 32'(bus.m0_rdata), 32'(0));
        check("rst_m1_rdata", 32'(bus.m1_rdata), 32'(0));
        check("rst_mem_we", 32'(bus.mem_we), 32'(0));
        check("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
        check("rst_mem_data", 32'(bus.mem_data), 32'(0));
        next_cycle();
        rst = 1'b0;

        // Port 0 write then read back
        do_single(0, 1'b1, 6'd5, 16'h1234, 16'h0000);
        do_single(0, 1'b0, 6'd5, 16'h0000, 16'h1234);
        idle_all();
        next_cycle();

        // Both ports held from reset: grants alternate 0,1,0,1
        do_reset();
        drive(0, 1'b1, 1'b0, 6'd5, '0);
        drive(1, 1'b1, 1'b0, 6'd5, '0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("alt_m0_ack_k%0d", k), 32'(bus.m0_ack), 32'((k >= 2) && ((k - 2) % 4 == 0)));
            check($sformatf("alt_m1_ack_k%0d", k), 32'(bus.m1_ack), 32'((k >= 4) && (k % 4 == 0)));
            if (bus.m0_ack) check("alt_m0_rdata", 32'(bus.m0_rdata), 32'h1234);
            if (bus.m1_ack) check("alt_m1_rdata", 32'(bus.m1_rdata), 32'h1234);
            next_cycle();
        end
        idle_all();
        repeat (4) next_cycle();

        // Contention: port 0 writes addr 3 first, port 1 then reads the new value
        do_reset();
        drive(0, 1'b1, 1'b1, 6'd3, 16'hBEEF);
        drive(1, 1'b1, 1'b0, 6'd3, '0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("cont_m0_ack_k%0d", k), 32'(bus.m0_ack), 32'(k == 2));
            check($sformatf("cont_m1_ack_k%0d", k), 32'(bus.m1_ack), 32'(k == 4));
            if (k == 4) check("cont_m1_rdata", 32'(bus.m1_rdata), 32'hBEEF);
            next_cycle();
            if (k == 2) drive(0, 1'b0, 1'b0, '0, '0);
        end
        idle_all();
        next_cycle();

        // Reset during the ACCESS cycle of a write: no commit, no ack
        do_single(0, 1'b1, 6'd7, 16'h0011, 16'h0000);
        drive(0, 1'b1, 1'b1, 6'd7, 16'h5555);
        @(negedge clk);
        check("rstacc_pre_we", 32'(bus.mem_we), 32'(0));
        next_cycle();
        check("rstacc_we_high", 32'(bus.mem_we), 32'(1));
        #1;
        rst = 1'b1;
        #1;
        check("rstacc_we_drop", 32'(bus.mem_we), 32'(0));
        check("rstacc_addr", 32'(bus.mem_addr), 32'(0));
        check("rstacc_data", 32'(bus.mem_data), 32'(0));
        check("rstacc_m0_rdata", 32'(bus.m0_rdata), 32'(0));
        idle_all();
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rstacc_no_ack", 32'({bus.m0_ack, bus.m1_ack}), 32'(0));
            next_cycle();
        end
        do_single(1, 1'b0, 6'd7, 16'h0000, 16'h0011);
        idle_all();
        next_cycle();

        // Reset during RESP: ack drops at once
        drive(1, 1'b1, 1'b0, 6'd5, '0);
        next_cycle();
        next_cycle();
        check("rstresp_ack_high", 32'(bus.m1_ack), 32'(1));
        #1;
        rst = 1'b1;
        #1;
        check("rstresp_ack_drop", 32'(bus.m1_ack), 32'(0));
        check("rstresp_m1_rdata", 32'(bus.m1_rdata), 32'(0));
        idle_all();
        next_cycle();
        rst = 1'b0;

        // Port 1 alone, three back-to-back transactions: acks at 2, 5, 8
        do_single(1, 1'b0, 6'd5, 16'h0000, 16'h1234);
        do_single(1, 1'b0, 6'd7, 16'h0000, 16'h0011);
        do_single(1, 1'b1, 6'd9, 16'hA5A5, 16'h0000);
        idle_all();
        next_cycle();

        // Preload every word through port 1 so the reference knows the memory image
        for (int a = 0; a < 64; a++) begin
            v = 16'($urandom);
            do_single(1, 1'b1, 6'(a), v, 16'h0000);
            ref_mem[a] = v;
        end
        idle_all();
        next_cycle();

        // Random traffic on both ports, checked at transaction level
        nwr = 0;
        we_pulses = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; pwe[p] = 1'b0; paddr[p] = '0; pdat[p] = '0; t0[p] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && c < 590 && $urandom_range(0, 2) != 0) begin
                    pend[p]  = 1'b1;
                    pwe[p]   = 1'($urandom_range(0, 1));
                    paddr[p] = 6'($urandom_range(0, 63));
                    pdat[p]  = 16'($urandom);
                    t0[p]    = c;
                end
                drive(p, pend[p], pwe[p], paddr[p], pdat[p]);
            end
            @(negedge clk);
            if (bus.mem_we) we_pulses++;
            check("rnd_one_ack", 32'(bus.m0_ack & bus.m1_ack), 32'(0));
            for (int p = 0; p < 2; p++) begin
                if (get_ack(p)) begin
                    check($sformatf("rnd_p%0d_ack_pending", p), 32'(pend[p]), 32'(1));
                    lat = c - t0[p];
                    check($sformatf("rnd_p%0d_latency_%0d", p, lat), 32'((lat >= 2) && (lat <= 4)), 32'(1));
                    if (pwe[p]) begin
                        ref_mem[paddr[p]] = pdat[p];
                        nwr++;
                    end else begin
                        check($sformatf("rnd_p%0d_rdata", p), 32'(get_rdata(p)), 32'(ref_mem[paddr[p]]));
                    end
                    pend[p] = 1'b0;
                end
            end
            next_cycle();
        end
        check("rnd_drained", 32'({pend[0], pend[1]}), 32'(0));
        check("rnd_we_pulses", 32'(we_pulses), 32'(nwr));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single-port, combinational-read `memory` block between two requesters: port 0 (CPU fetch/execute) and port 1 (I/O or loader). It latches one requester's transaction, drives the memory address/data/write-enable for exactly one access cycle, captures read data, and returns a one-cycle acknowledge. It sits between the CPU/peripheral side and the `memory` instance; nothing else drives the memory ports.

## Interface
- `ADDR_WIDTH`, 6, memory address width; must match `memory`.
- `DATA_WIDTH`, 16, memory word width; must match `memory`.

Ports:
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_req`  in  1  port 0 request; held high with stable `m0_we/m0_addr/m0_wdata` until `m0_ack`.
- `m0_we`  in  1  port 0 write (1) / read (0).
- `m0_addr`  in  ADDR_WIDTH  port 0 address.
- `m0_wdata`  in  DATA_WIDTH  port 0 write data.
- `m0_ack`  out  1  one-cycle pulse: port 0 transaction complete.
- `m0_rdata`  out  DATA_WIDTH  port 0 read data; valid while `m0_ack`=1, held until next port 0 read completes.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_ack`, `m1_rdata`: identical for port 1.
- `mem_we`  out  1  to `memory.we`.
- `mem_addr`  out  ADDR_WIDTH  to `memory.addr`.
- `mem_data`  out  DATA_WIDTH  to `memory.data`.
- `mem_out`  in  DATA_WIDTH  from `memory.out` (combinational read of `mem_addr`).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any `mX_req`, pick winner, latch its `we/addr/wdata` and port id, go ACCESS; else stay.
- ACCESS (exactly 1 cycle): `mem_addr`=latched addr, `mem_data`=latched wdata, `mem_we`=latched we. At the closing edge: memory commits a write; for reads `mem_out` is captured into the winner's `rdata` register. Go RESP.
- RESP (1 cycle): winner's `ack`=1. The winner's `req` is ignored this cycle. If the other port's `req`=1, latch it and go ACCESS; else go IDLE.
- Arbitration: round robin via `last_grant` register. Both requesting in IDLE -> grant port != `last_grant`. Single requester always wins. `last_grant` updates on each grant.
- Write transactions do not modify `mX_rdata`.
- `mem_we` decoded from state (ACCESS & latched we); never high outside ACCESS.
- Outside ACCESS, `mem_addr`/`mem_data` hold last latched values.
- Requester must drop `req` in the cycle after `ack`, or keep it high to issue a new transaction (which is then arbitrated normally).

## Timing
- Reset values: state IDLE, `m0_ack`=`m1_ack`=0, `m0_rdata`=`m1_rdata`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, `last_grant`=1 (port 0 wins first tie).
- Latency, idle arbiter: `req` high in cycle N -> ACCESS in N+1 -> `ack` in N+2.
- Back-to-back other port: served ACCESS in the cycle after the first port's RESP; sustained alternating throughput 1 transaction / 2 cycles; single port 1 / 3 cycles.
- Reset asserted during ACCESS: `mem_we` falls immediately (async), write is not committed, no `ack` issued, latched transaction discarded.
- Reset asserted during RESP: `ack` drops immediately; requester must reissue.
- `req` deasserted by requester before `ack`: illegal; arbiter still completes the latched transaction.

## Test plan
- Reset: assert `rst` mid-run -> all outputs at reset values within same cycle, state IDLE.
- Port 0 write 0x1234 to addr 5, then port 0 read addr 5 -> `mem_we`=1 for exactly one cycle, `m0_ack` at N+2 each, `m0_rdata`=0x1234 on read ack.
- Simultaneous `m0_req`/`m1_req` from reset, both held -> grants 0,1,0,1...; acks alternate, each port ack every 4 cycles.
- Port 1 read addr 3 while port 0 write addr 3 value 0xBEEF contends, port 0 granted first -> port 1 reads 0xBEEF.
- `rst` pulsed during ACCESS of a write to addr 7 (previously 0x0011) -> no ack, addr 7 still 0x0011.
- Only port 1 requesting continuously for 3 transactions -> acks at cycles 2, 5, 8; `m0_ack` never asserts.
